// File: rtl/sram_march_bist.sv
// March C- built-in self test engine for a single-port synchronous SRAM.
// It walks the six March C- elements over addresses 0..ADDR_MAX and drives
// the same registered address / write-data / we_n bus as any other SRAM
// master. Reads are checked through a compare pipeline that matches the SRAM
// read latency.
//
// Bus handshake: there is no valid/ready pair. While a run is active, every
// clock cycle carries exactly one operation on the registered bus: a write
// when BIST_we_n is 0, otherwise a read. The word for a read appears on
// BIST_read_data RD_LAT cycles after the cycle in which its address was
// presented, and the SRAM is assumed never to stall.
module sram_march_bist #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int ADDR_MAX = 2**ADDR_W - 1,
    parameter int RD_LAT   = 2,
    parameter int CNT_W    = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              BIST_start,
    input  logic              BIST_abort,
    input  logic              BIST_mode,
    output logic [ADDR_W-1:0] BIST_address,
    output logic [DATA_W-1:0] BIST_write_data,
    output logic              BIST_we_n,
    input  logic [DATA_W-1:0] BIST_read_data,
    output logic              BIST_finish,
    output logic              BIST_mismatch,
    output logic [ADDR_W-1:0] BIST_fail_address,
    output logic [CNT_W-1:0]  BIST_fail_count
);

    // The drain counter only has to count up to RD_LAT-1.
    localparam int                DRN_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

    // March elements, numbered in the order they execute.
    localparam logic [2:0] M0 = 3'd0;  // up   (w0)
    localparam logic [2:0] M1 = 3'd1;  // up   (r0,w1)
    localparam logic [2:0] M2 = 3'd2;  // up   (r1,w0)
    localparam logic [2:0] M3 = 3'd3;  // down (r0,w1)
    localparam logic [2:0] M4 = 3'd4;  // down (r1,w0)
    localparam logic [2:0] M5 = 3'd5;  // down (r0)

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Background pattern for one address. Solid mode is all zeros. In
    // checkerboard mode even addresses hold ...0101 and odd ones ...1010.
    function automatic logic [DATA_W-1:0] bg_word(input logic mode, input logic a0);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = mode & (a0 ^ ((i % 2) == 0));
        end
        return r;
    endfunction

    // Logical cell value: "0" is the background, "1" is its complement.
    function automatic logic [DATA_W-1:0] cell_word(input logic mode, input logic a0,
                                                     input logic one);
        return bg_word(mode, a0) ^ {DATA_W{one}};
    endfunction

    // Value each element expects when it reads.
    function automatic logic elem_rd_one(input logic [2:0] e);
        return (e == M2) || (e == M4);
    endfunction

    // Value each element writes.
    function automatic logic elem_wr_one(input logic [2:0] e);
        return (e == M1) || (e == M3);
    endfunction

    // Registered state.
    state_t              state_q, state_d;
    logic [2:0]          elem_q, elem_d;
    logic                mode_q, mode_d;
    logic                start_q, start_d;
    logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_n_q, we_n_d;
    logic                finish_q, finish_d;
    logic                mismatch_q, mismatch_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;

    // Compare pipeline: one entry per read issued, aligned with its read data.
    logic                pipe_valid_q [RD_LAT];
    logic                pipe_valid_d [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_q   [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_d   [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_q  [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_d  [RD_LAT];

    // Helper nets.
    logic                start_edge;
    logic                elem_up;
    logic                elem_end;
    logic [ADDR_W-1:0]   addr_step;
    logic [2:0]          elem_next;
    logic [ADDR_W-1:0]   elem_next_addr;
    logic                cmp_fail;

    assign start_edge     = BIST_start & ~start_q;
    assign elem_up        = (elem_q <= M2);
    assign elem_end       = elem_up ? (addr_q == ADDR_LAST) : (addr_q == '0);
    assign addr_step      = elem_up ? (addr_q + ADDR_W'(1)) : (addr_q - ADDR_W'(1));
    assign elem_next      = elem_q + 3'd1;
    assign elem_next_addr = (elem_next <= M2) ? '0 : ADDR_LAST;
    assign cmp_fail       = pipe_valid_q[RD_LAT-1] &&
                            (BIST_read_data != pipe_exp_q[RD_LAT-1]);

    // Next-state logic: march sequencing, compare pipeline and fail capture.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        mode_d      = mode_q;
        start_d     = BIST_start;
        drain_cnt_d = drain_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        finish_d    = finish_q;
        mismatch_d  = mismatch_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;

        // Shift the compare pipeline; stage 0 is loaded only by a read.
        pipe_valid_d[0] = 1'b0;
        pipe_exp_d[0]   = pipe_exp_q[0];
        pipe_addr_d[0]  = pipe_addr_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_exp_d[i]   = pipe_exp_q[i-1];
            pipe_addr_d[i]  = pipe_addr_q[i-1];
        end

        // Check the read word that lines up with the oldest pipeline entry.
        if (cmp_fail) begin
            mismatch_d = 1'b1;
            if (fail_cnt_q != CNT_SAT) begin
                fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
            if (!mismatch_q) begin
                fail_addr_d = pipe_addr_q[RD_LAT-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                finish_d = 1'b1;
                if (start_edge) begin
                    finish_d    = 1'b0;
                    mismatch_d  = 1'b0;
                    fail_addr_d = '0;
                    fail_cnt_d  = '0;
                    mode_d      = BIST_mode;
                    elem_d      = M0;
                    addr_d      = '0;
                    state_d     = S_WRITE;
                    we_n_d      = 1'b0;
                    wdata_d     = cell_word(BIST_mode, 1'b0, 1'b0);
                end
            end

            S_READ: begin
                // The read on the bus this cycle is in flight even if we abort now.
                pipe_valid_d[0] = 1'b1;
                pipe_exp_d[0]   = cell_word(mode_q, addr_q[0], elem_rd_one(elem_q));
                pipe_addr_d[0]  = addr_q;
                if (BIST_abort) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else if (elem_q == M5) begin
                    if (elem_end) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        addr_d = addr_step;
                    end
                end else begin
                    state_d = S_WRITE;
                    we_n_d  = 1'b0;
                    wdata_d = cell_word(mode_q, addr_q[0], elem_wr_one(elem_q));
                end
            end

            S_WRITE: begin
                if (BIST_abort) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else if (elem_end) begin
                    // Every element after M0 starts with a read.
                    elem_d  = elem_next;
                    addr_d  = elem_next_addr;
                    state_d = S_READ;
                end else if (elem_q == M0) begin
                    addr_d  = addr_step;
                    we_n_d  = 1'b0;
                    wdata_d = cell_word(mode_q, addr_step[0], 1'b0);
                end else begin
                    addr_d  = addr_step;
                    state_d = S_READ;
                end
            end

            S_DRAIN: begin
                // Let the last RD_LAT reads reach the comparator before finishing.
                if (drain_cnt_q == DRN_LAST) begin
                    state_d  = S_IDLE;
                    finish_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            elem_q      <= M0;
            mode_q      <= 1'b0;
            start_q     <= 1'b0;
            drain_cnt_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            finish_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_exp_q[i]   <= '0;
                pipe_addr_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            drain_cnt_q <= drain_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            finish_q    <= finish_d;
            mismatch_q  <= mismatch_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_exp_q[i]   <= pipe_exp_d[i];
                pipe_addr_q[i]  <= pipe_addr_d[i];
            end
        end
    end

    assign BIST_address      = addr_q;
    assign BIST_write_data   = wdata_q;
    assign BIST_we_n         = we_n_q;
    assign BIST_finish       = finish_q;
    assign BIST_mismatch     = mismatch_q;
    assign BIST_fail_address = fail_addr_q;
    assign BIST_fail_count   = fail_cnt_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist. Two engines share clock and reset:
// dut_a (16 words, RD_LAT=2) and dut_b (10 words, RD_LAT=3, 2-bit fail
// counter). Each engine talks to a simple SRAM model that can inject faults.
module tb_sram_march_bist;

  logic clk;
  logic rst;

  // dut_a signals
  logic        start_a, abort_a, mode_a;
  logic [3:0]  addr_a;
  logic [15:0] wdata_a;
  logic        we_n_a;
  logic [15:0] rdata_a;
  logic        finish_a, mism_a;
  logic [3:0]  faddr_a;
  logic [7:0]  fcnt_a;

  // dut_b signals
  logic        start_b, abort_b, mode_b;
  logic [3:0]  addr_b;
  logic [15:0] wdata_b;
  logic        we_n_b;
  logic [15:0] rdata_b;
  logic        finish_b, mism_b;
  logic [3:0]  faddr_b;
  logic [1:0]  fcnt_b;

  // SRAM models and fault controls
  logic [15:0] mem_a [16];
  logic [15:0] rdp_a [2];
  logic [15:0] mem_b [16];
  logic [15:0] rdp_b [3];
  logic        fault_a;
  logic        fault_b;

  // Write monitor log for dut_a
  int          wr_total_a;
  logic [15:0] wr_data_log [2048];
  logic [3:0]  wr_addr_log [2048];

  // Scoreboard
  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  sram_march_bist #(
    .ADDR_W(4), .DATA_W(16), .ADDR_MAX(15), .RD_LAT(2), .CNT_W(8)
  ) dut_a (
    .Clock(clk), .Reset(rst),
    .BIST_start(start_a), .BIST_abort(abort_a), .BIST_mode(mode_a),
    .BIST_address(addr_a), .BIST_write_data(wdata_a), .BIST_we_n(we_n_a),
    .BIST_read_data(rdata_a), .BIST_finish(finish_a), .BIST_mismatch(mism_a),
    .BIST_fail_address(faddr_a), .BIST_fail_count(fcnt_a)
  );

  sram_march_bist #(
    .ADDR_W(4), .DATA_W(16), .ADDR_MAX(9), .RD_LAT(3), .CNT_W(2)
  ) dut_b (
    .Clock(clk), .Reset(rst),
    .BIST_start(start_b), .BIST_abort(abort_b), .BIST_mode(mode_b),
    .BIST_address(addr_b), .BIST_write_data(wdata_b), .BIST_we_n(we_n_b),
    .BIST_read_data(rdata_b), .BIST_finish(finish_b), .BIST_mismatch(mism_b),
    .BIST_fail_address(faddr_b), .BIST_fail_count(fcnt_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for dut_a: stuck-at-1 on bit 3 of address 5 when fault_a is set.
  always @(posedge clk) begin
    if (!we_n_a) begin
      mem_a[addr_a] <= wdata_a;
      if (wr_total_a < 2048) begin
        wr_data_log[wr_total_a[10:0]] <= wdata_a;
        wr_addr_log[wr_total_a[10:0]] <= addr_a;
      end
      wr_total_a <= wr_total_a + 1;
    end
    rdp_a[0] <= mem_a[addr_a] | ((fault_a && addr_a == 4'd5) ? 16'h0008 : 16'h0000);
    rdp_a[1] <= rdp_a[0];
  end
  assign rdata_a = rdp_a[1];

  // SRAM model for dut_b: bit 0 of address 9 reads inverted when fault_b is set.
  always @(posedge clk) begin
    if (!we_n_b) mem_b[addr_b] <= wdata_b;
    rdp_b[0] <= mem_b[addr_b] ^ ((fault_b && addr_b == 4'd9) ? 16'h0001 : 16'h0000);
    rdp_b[1] <= rdp_b[0];
    rdp_b[2] <= rdp_b[1];
  end
  assign rdata_b = rdp_b[2];

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start dut_a and count cycles from the start-sampling edge until finish.
  // With poke_start set, a second start pulse is sent mid-run.
  task automatic run_a(input logic mode, input logic poke_start, output int cyc);
    @(negedge clk);
    mode_a  = mode;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    cyc = 0;
    while (finish_a !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
      if (poke_start && cyc == 50) start_a = 1'b1;
      if (poke_start && cyc == 51) start_a = 1'b0;
    end
  endtask

  task automatic run_b(output int cyc);
    @(negedge clk);
    mode_b  = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (finish_b !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int base;
    int snap;

    n_checks = 0;
    n_errors = 0;
    wr_total_a = 0;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0; fault_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 1'b0; fault_b = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_addr",     32'(addr_a),   32'h0);
    check("rst_wdata",    32'(wdata_a),  32'h0);
    check("rst_we_n",     32'(we_n_a),   32'h1);
    check("rst_finish",   32'(finish_a), 32'h0);
    check("rst_mismatch", 32'(mism_a),   32'h0);
    check("rst_faddr",    32'(faddr_a),  32'h0);
    check("rst_fcnt",     32'(fcnt_a),   32'h0);
    check("rst_b_we_n",   32'(we_n_b),   32'h1);
    rst = 1'b0;
    step();
    check("idle_finish",  32'(finish_a), 32'h1);
    check("idle_b_finish", 32'(finish_b), 32'h1);

    // Abort while idle has no effect
    abort_a = 1'b1;
    step();
    step();
    check("idle_abort_finish", 32'(finish_a), 32'h1);
    check("idle_abort_we_n",   32'(we_n_a),   32'h1);
    abort_a = 1'b0;
    step();

    // Clean run, solid background: 10*16 + 2 cycles
    run_a(1'b0, 1'b0, cyc);
    check("solid_len",      32'(cyc),     32'd162);
    check("solid_mismatch", 32'(mism_a),  32'h0);
    check("solid_fcnt",     32'(fcnt_a),  32'h0);
    check("solid_mem0",     32'(mem_a[0]),  32'h0);
    check("solid_mem15",    32'(mem_a[15]), 32'h0);

    // Clean run, checkerboard, with an ignored start pulse mid-run
    base = wr_total_a;
    run_a(1'b1, 1'b1, cyc);
    check("chk_len",      32'(cyc),    32'd162);
    check("chk_mismatch", 32'(mism_a), 32'h0);
    check("chk_writes",   32'(wr_total_a - base), 32'd80);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back((i % 2 == 0) ? 16'h5555 : 16'hAAAA);
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check($sformatf("chk_m0_data[%0d]", i), 32'(wr_data_log[base + i]), 32'(e));
      check($sformatf("chk_m0_addr[%0d]", i), 32'(wr_addr_log[base + i]), 32'(i));
    end
    check("chk_mem_even", 32'(mem_a[4]), 32'h5555);
    check("chk_mem_odd",  32'(mem_a[7]), 32'hAAAA);

    // Stuck-at-1 bit 3 at address 5: the three r0 reads there fail
    fault_a = 1'b1;
    run_a(1'b0, 1'b0, cyc);
    fault_a = 1'b0;
    check("sa1_len",      32'(cyc),     32'd162);
    check("sa1_mismatch", 32'(mism_a),  32'h1);
    check("sa1_faddr",    32'(faddr_a), 32'd5);
    check("sa1_fcnt",     32'(fcnt_a),  32'd3);

    // A new start clears the previous fail record
    run_a(1'b0, 1'b0, cyc);
    check("clear_mismatch", 32'(mism_a),  32'h0);
    check("clear_faddr",    32'(faddr_a), 32'h0);
    check("clear_fcnt",     32'(fcnt_a),  32'h0);

    // Abort 40 cycles into a run
    @(negedge clk);
    mode_a  = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (40) step();
    abort_a = 1'b1;
    step();
    snap = wr_total_a;
    check("abort_we_n",    32'(we_n_a),   32'h1);
    check("abort_fin0",    32'(finish_a), 32'h0);
    step();
    check("abort_fin1",    32'(finish_a), 32'h0);
    step();
    check("abort_fin2",    32'(finish_a), 32'h1);
    abort_a = 1'b0;
    repeat (4) step();
    check("abort_no_writes", 32'(wr_total_a - snap), 32'd0);
    check("abort_mismatch",  32'(mism_a), 32'h0);
    check("abort_idle_we_n", 32'(we_n_a), 32'h1);

    // Reset in the middle of M2, with a fault so the fail record is non-zero
    fault_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (60) step();
    check("mid_pre_mismatch", 32'(mism_a), 32'h1);
    rst = 1'b1;
    step();
    snap = wr_total_a;
    check("mid_rst_addr",     32'(addr_a),   32'h0);
    check("mid_rst_wdata",    32'(wdata_a),  32'h0);
    check("mid_rst_we_n",     32'(we_n_a),   32'h1);
    check("mid_rst_finish",   32'(finish_a), 32'h0);
    check("mid_rst_mismatch", 32'(mism_a),   32'h0);
    check("mid_rst_faddr",    32'(faddr_a),  32'h0);
    check("mid_rst_fcnt",     32'(fcnt_a),   32'h0);
    step();
    step();
    rst = 1'b0;
    fault_a = 1'b0;
    repeat (3) step();
    check("mid_rst_no_writes", 32'(wr_total_a - snap), 32'd0);
    run_a(1'b0, 1'b0, cyc);
    check("post_rst_len",      32'(cyc),    32'd162);
    check("post_rst_mismatch", 32'(mism_a), 32'h0);
    check("post_rst_fcnt",     32'(fcnt_a), 32'h0);

    // dut_b: 10 words, RD_LAT=3 -> 10*10 + 3 cycles
    run_b(cyc);
    check("b_len",      32'(cyc),    32'd103);
    check("b_mismatch", 32'(mism_b), 32'h0);
    check("b_fcnt",     32'(fcnt_b), 32'h0);

    // Read fault at the last address: five failing reads saturate a 2-bit counter
    fault_b = 1'b1;
    run_b(cyc);
    fault_b = 1'b0;
    check("b_fault_len",      32'(cyc),     32'd103);
    check("b_fault_mismatch", 32'(mism_b),  32'h1);
    check("b_fault_faddr",    32'(faddr_b), 32'd9);
    check("b_fault_fcnt_sat", 32'(fcnt_b),  32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
